// File: rtl/filter2d_pkg.sv
// Shared constants, types and helpers for the streaming 3x3 image filter.
package filter2d_pkg;

  localparam logic [3:0] IDX_SHIFT  = 4'd9;
  localparam logic [3:0] IDX_BORDER = 4'd10;

  localparam int unsigned NumTaps   = 9;
  localparam int unsigned CentreTap = 4;

  typedef enum logic {
    BorderZero      = 1'b0,
    BorderReplicate = 1'b1
  } border_e;

  // Nine full-range products need four guard bits on top of pixel+coef+sign.
  function automatic int unsigned acc_width(int unsigned dw, int unsigned cw);
    return dw + cw + 5;
  endfunction

  function automatic int identity_coef(int tap);
    return (tap == int'(CentreTap)) ? 1 : 0;
  endfunction

endpackage

// File: rtl/filter2d_linebuf.sv
// Two row buffers sharing one column address; row2 holds the row above row1.
module filter2d_linebuf
  import filter2d_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned DW    = 8
) (
  input  logic                       clk,
  input  logic                       adv,
  input  logic [$clog2(IMG_W)-1:0]   col,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_row1,
  output logic [DW-1:0]              rd_row2
);

  logic [DW-1:0] row1_mem [IMG_W];
  logic [DW-1:0] row2_mem [IMG_W];

  assign rd_row1 = row1_mem[col];
  assign rd_row2 = row2_mem[col];

  always_ff @(posedge clk) begin
    if (adv) begin
      row1_mem[col] <= wr_data;
      row2_mem[col] <= row1_mem[col];
    end
  end

endmodule

// File: rtl/filter2d_stream.sv
// Streaming 3x3 filter: programmable signed taps, rounding shift, border mode,
// frame-aligned settings commit and an end-of-frame flush.
module filter2d_stream
  import filter2d_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_strb,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  output logic          o_strb,
  output logic [DW-1:0] o_data,
  input  logic          h_write,
  input  logic [3:0]    h_idx,
  input  logic [CW-1:0] h_data,
  output logic          o_err
);

  localparam int unsigned ColW  = $clog2(IMG_W);
  localparam int unsigned RowW  = $clog2(IMG_H + 2);
  localparam int unsigned AccW  = acc_width(DW, CW);
  localparam int unsigned ProdW = DW + CW + 1;
  localparam int unsigned RndW  = AccW + 32;

  // Trigger position: rows IMG_H and IMG_H+1 are the flush ticks.
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic            flushing, accept, trigger, first_px;
  logic            err_q;

  assign flushing = (row_q >= RowW'(IMG_H));
  assign i_ready  = ~flushing;
  assign accept   = i_strb & ~flushing;
  assign trigger  = accept | flushing;
  assign first_px = accept & (row_q == '0) & (col_q == '0);
  assign o_err    = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (i_strb & flushing) err_q <= 1'b1;
      if (trigger) begin
        if (row_q == RowW'(IMG_H + 1)) begin
          col_q <= '0;
          row_q <= '0;
        end else if (col_q == ColW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end
    end
  end

  // Host settings: shadow bank written any time, copied to active at pixel (0,0).
  logic signed [CW-1:0] coef_sh_q [NumTaps];
  logic signed [CW-1:0] coef_q    [NumTaps];
  logic [4:0]           shift_sh_q, shift_q;
  border_e              border_sh_q, border_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NumTaps); k++) begin
        coef_sh_q[k] <= CW'(identity_coef(k));
        coef_q[k]    <= CW'(identity_coef(k));
      end
      shift_sh_q  <= '0;
      shift_q     <= '0;
      border_sh_q <= BorderZero;
      border_q    <= BorderZero;
    end else begin
      if (first_px) begin
        for (int k = 0; k < int'(NumTaps); k++) coef_q[k] <= coef_sh_q[k];
        shift_q  <= shift_sh_q;
        border_q <= border_sh_q;
      end
      if (h_write) begin
        for (int k = 0; k < int'(NumTaps); k++) begin
          if (h_idx == 4'(k)) coef_sh_q[k] <= h_data;
        end
        if (h_idx == IDX_SHIFT)  shift_sh_q  <= h_data[4:0];
        if (h_idx == IDX_BORDER) border_sh_q <= border_e'(h_data[0]);
      end
    end
  end

  // Window: row 0 = above centre, row 2 = below; column 2 = newest.
  logic [DW-1:0] new_px, lb_top, lb_mid;
  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] win_d [3][3];

  assign new_px = accept ? i_data : '0;

  filter2d_linebuf #(
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_linebuf (
    .clk     (clk),
    .adv     (trigger),
    .col     (col_q),
    .wr_data (new_px),
    .rd_row1 (lb_mid),
    .rd_row2 (lb_top)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) win_d[i][j] = win_q[i][j+1];
    end
    win_d[0][2] = lb_top;
    win_d[1][2] = lb_mid;
    win_d[2][2] = new_px;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      end
    end else if (trigger) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= win_d[i][j];
      end
    end
  end

  // Centre pixel lags the newest trigger by one row plus one column.
  logic            cen_valid;
  logic [ColW-1:0] cen_c;
  logic [RowW-1:0] cen_r;
  logic [2:0]      oob_r, oob_c;

  always_comb begin
    cen_valid = (row_q >= RowW'(2)) | ((row_q == RowW'(1)) & (col_q != '0));
    if (col_q == '0) begin
      cen_c = ColW'(IMG_W - 1);
      cen_r = row_q - RowW'(2);
    end else begin
      cen_c = col_q - ColW'(1);
      cen_r = row_q - RowW'(1);
    end
    oob_r = {cen_r == RowW'(IMG_H - 1), 1'b0, cen_r == '0};
    oob_c = {cen_c == ColW'(IMG_W - 1), 1'b0, cen_c == '0};
  end

  logic signed [ProdW-1:0] prod [NumTaps];
  logic [DW-1:0]           tap_px;

  always_comb begin
    tap_px = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((oob_r[i] | oob_c[j]) & (border_q == BorderZero)) begin
          tap_px = '0;
        end else begin
          tap_px = win_d[oob_r[i] ? 1 : i][oob_c[j] ? 1 : j];
        end
        prod[i*3+j] = ProdW'(signed'({1'b0, tap_px})) * ProdW'(coef_q[i*3+j]);
      end
    end
  end

  // Stage 1: products.
  logic signed [ProdW-1:0] s1_prod_q [NumTaps];
  logic                    s1_vld_q;
  logic [4:0]              s1_shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NumTaps); k++) s1_prod_q[k] <= '0;
      s1_vld_q   <= 1'b0;
      s1_shift_q <= '0;
    end else begin
      for (int k = 0; k < int'(NumTaps); k++) s1_prod_q[k] <= prod[k];
      s1_vld_q   <= trigger & cen_valid;
      s1_shift_q <= shift_q;
    end
  end

  // Stage 2: sum and round; widened so the rounding constant never overflows.
  logic signed [AccW-1:0] sum, s2_d, s2_q;
  logic signed [RndW-1:0] rnd, rounded;
  logic                   s2_vld_q;

  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(NumTaps); k++) sum = sum + AccW'(s1_prod_q[k]);
    rnd = '0;
    if (s1_shift_q != '0) rnd = RndW'(1) <<< (s1_shift_q - 5'd1);
    rounded = (RndW'(sum) + rnd) >>> s1_shift_q;
    s2_d    = AccW'(rounded);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_q     <= s2_d;
      s2_vld_q <= s1_vld_q;
    end
  end

  // Stage 3: clamp to pixel range.
  logic [DW-1:0] clamp;
  logic          o_strb_q;
  logic [DW-1:0] o_data_q;

  always_comb begin
    if (s2_q[AccW-1])            clamp = '0;
    else if (|s2_q[AccW-2:DW])   clamp = '1;
    else                         clamp = s2_q[DW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_strb_q <= 1'b0;
      o_data_q <= '0;
    end else begin
      o_strb_q <= s2_vld_q;
      if (s2_vld_q) o_data_q <= clamp;
    end
  end

  assign o_strb = o_strb_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_filter2d_stream.sv
// Randomised bench for filter2d_stream on a 4x4 image with a frame-level reference model.
module tb_filter2d_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_strb;
  logic [7:0] i_data;
  logic       i_ready;
  logic       o_strb;
  logic [7:0] o_data;
  logic       h_write;
  logic [3:0] h_idx;
  logic [7:0] h_data;
  logic       o_err;

  filter2d_stream #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (8),
    .CW    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_strb  (i_strb),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_strb  (o_strb),
    .o_data  (o_data),
    .h_write (h_write),
    .h_idx   (h_idx),
    .h_data  (h_data),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int out_log[$];
  int cyc = 0;
  int lat_start = -1;
  int first_strb = -1;

  int img[N];
  int sh_coef[9], act_coef[9];
  int sh_shift, act_shift, sh_border, act_border;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: direct 3x3 neighbourhood sum over the stored frame.
  function automatic int model_px(int r, int c);
    longint sum = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        bit out = (rr < 0) || (rr >= H) || (cc < 0) || (cc >= W);
        if (!(out && act_border == 0)) begin
          if (rr < 0) rr = 0;
          if (rr >= H) rr = H - 1;
          if (cc < 0) cc = 0;
          if (cc >= W) cc = W - 1;
          sum += longint'(img[rr*W+cc]) * longint'(act_coef[(dr+1)*3+(dc+1)]);
        end
      end
    end
    if (act_shift > 0) sum = (sum + (longint'(1) <<< (act_shift - 1))) >>> act_shift;
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return int'(sum);
  endfunction

  function automatic void shadow_write(int idx, int data);
    int v = data & 255;
    if (idx < 9) sh_coef[idx] = (v > 127) ? v - 256 : v;
    else if (idx == 9) sh_shift = v & 31;
    else if (idx == 10) sh_border = v & 1;
  endfunction

  function automatic void shadow_identity();
    for (int k = 0; k < 9; k++) sh_coef[k] = (k == 4) ? 1 : 0;
    sh_shift = 0;
    sh_border = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(int idx, int data);
    h_write = 1'b1;
    h_idx   = 4'(idx);
    h_data  = 8'(data);
    tick();
    h_write = 1'b0;
    shadow_write(idx, data);
  endtask

  task automatic commit_and_expect(int count);
    for (int k = 0; k < 9; k++) act_coef[k] = sh_coef[k];
    act_shift  = sh_shift;
    act_border = sh_border;
    for (int p = 0; p < count; p++) exp_q.push_back(model_px(p / W, p % W));
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (i_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (i_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got i_ready=%b expected 1", i_ready);
    end
  endtask

  task automatic send_frame(int gap, int wr_at, int wr_idx, int wr_data, bit bad_strb);
    wait_ready();
    commit_and_expect(N);
    for (int p = 0; p < N; p++) begin
      i_strb = 1'b1;
      i_data = 8'(img[p]);
      if (p == wr_at) begin
        h_write = 1'b1;
        h_idx   = 4'(wr_idx);
        h_data  = 8'(wr_data);
      end
      if (p == 5 && lat_start < 0) lat_start = cyc;
      tick();
      i_strb  = 1'b0;
      h_write = 1'b0;
      if (p == wr_at) shadow_write(wr_idx, wr_data);
      repeat (gap) tick();
    end
    if (bad_strb) begin
      i_strb = 1'b1;
      i_data = 8'd200;
      tick();
      i_strb = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() > 0 && waited < 300) begin
      tick();
      waited++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (8) tick();
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && o_strb === 1'b1) begin
      if (first_strb < 0) first_strb = cyc;
      out_log.push_back(int'(o_data));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_output: got o_data=%0d expected no strobe", o_data);
      end else begin
        check("o_data", int'(o_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_strb = 1'b0; i_data = '0;
    h_write = 1'b0; h_idx = '0; h_data = '0;
    shadow_identity();
    tick();
    tick();
    check("rst_o_strb", int'(o_strb), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_i_ready", int'(i_ready), 1);
    check("rst_o_err", int'(o_err), 0);
    reset = 1'b0;
    tick();

    // Pin the model against hand-computed values.
    for (int k = 0; k < 9; k++) act_coef[k] = 1;
    act_shift = 3; act_border = 0;
    for (int p = 0; p < N; p++) img[p] = 80;
    check("pin_interior", model_px(1, 1), 90);
    check("pin_edge", model_px(0, 2), 60);
    check("pin_corner", model_px(3, 3), 40);
    act_border = 1;
    check("pin_repl_corner", model_px(0, 0), 90);
    for (int k = 0; k < 9; k++) act_coef[k] = (k == 4) ? 4 : 0;
    act_shift = 0;
    for (int p = 0; p < N; p++) img[p] = 100;
    check("pin_saturate", model_px(2, 2), 255);
    act_coef[4] = -1;
    check("pin_negative", model_px(1, 2), 0);
    act_coef[4] = 3; act_shift = 1;
    for (int p = 0; p < N; p++) img[p] = 1;
    check("pin_round", model_px(2, 1), 2);

    // Identity ramp, back-to-back, with flush timing.
    for (int p = 0; p < N; p++) img[p] = p;
    out_log.delete();
    send_frame(0, -1, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("i_ready_flush", int'(i_ready), 0);
      tick();
    end
    check("i_ready_back", int'(i_ready), 1);
    drain();
    check("latency", first_strb - lat_start, 3);
    check("ramp_count", out_log.size(), N);
    for (int p = 0; p < N && p < out_log.size(); p++) check("ramp_value", out_log[p], p);

    // Box filter, zero then replicate border.
    for (int k = 0; k < 9; k++) host_write(k, 1);
    host_write(9, 3);
    host_write(10, 0);
    for (int p = 0; p < N; p++) img[p] = 80;
    out_log.delete();
    send_frame(0, -1, 0, 0, 1'b0);
    drain();
    check("box_corner", out_log[0], 40);
    check("box_interior", out_log[5], 90);
    host_write(10, 1);
    out_log.delete();
    send_frame(0, -1, 0, 0, 1'b0);
    drain();
    check("box_repl_corner", out_log[0], 90);

    // Saturation, negative clamp, rounding.
    for (int k = 0; k < 9; k++) host_write(k, (k == 4) ? 4 : 0);
    host_write(9, 0);
    host_write(10, 0);
    for (int p = 0; p < N; p++) img[p] = 100;
    send_frame(0, -1, 0, 0, 1'b0);
    host_write(4, 8'hFF);
    send_frame(0, -1, 0, 0, 1'b0);
    host_write(4, 3);
    host_write(9, 1);
    for (int p = 0; p < N; p++) img[p] = 1;
    send_frame(0, -1, 0, 0, 1'b0);
    drain();

    // Mid-frame write affects only the next frame; write at pixel 0 likewise.
    host_write(4, 1);
    host_write(9, 0);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 120);
    send_frame(0, 7, 4, 2, 1'b0);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 120);
    send_frame(0, 0, 4, 1, 1'b0);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
    send_frame(0, -1, 0, 0, 1'b0);
    drain();

    // Strobe during flush is dropped and sets the sticky error.
    check("err_before", int'(o_err), 0);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
    send_frame(0, -1, 0, 0, 1'b1);
    check("err_set", int'(o_err), 1);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
    send_frame(0, -1, 0, 0, 1'b0);
    drain();
    check("err_sticky", int'(o_err), 1);

    // Random frames with random settings, gaps and in-frame writes.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 9; k++) begin
        if ($urandom_range(0, 1) == 1) host_write(k, $urandom_range(0, 255));
        else host_write(k, int'($urandom_range(0, 8)) - 4);
      end
      host_write(9, $urandom_range(0, 9));
      host_write(10, $urandom_range(0, 1));
      host_write(int'($urandom_range(11, 15)), $urandom_range(0, 255));
      for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
      send_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 16)) - 1,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
        send_frame(0, -1, 0, 0, 1'b0);
      end
    end
    drain();

    // Partial frame with idle gaps, then reset mid-frame.
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
    wait_ready();
    commit_and_expect(3);
    for (int p = 0; p < 8; p++) begin
      i_strb = 1'b1;
      i_data = 8'(img[p]);
      tick();
      i_strb = 1'b0;
      repeat (16) tick();
    end
    check("partial_outputs", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_mid_o_strb", int'(o_strb), 0);
      check("rst_mid_o_data", int'(o_data), 0);
      tick();
    end
    exp_q.delete();
    reset = 1'b0;
    shadow_identity();
    check("rst_mid_o_err", int'(o_err), 0);
    check("rst_mid_i_ready", int'(i_ready), 1);
    for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
    out_log.delete();
    send_frame(16, -1, 0, 0, 1'b0);
    drain();
    check("post_rst_count", out_log.size(), N);
    for (int p = 0; p < N && p < out_log.size(); p++) check("post_rst_identity", out_log[p], img[p]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter2d_stream.md
Name: filter2d_stream

Overview:
- Parametrised successor to the fixed 3x3 image filter: streams a raster image of IMG_W x IMG_H pixels, one pixel per input strobe, and emits one filtered pixel per input pixel in raster order.
- Adds signed host-programmable coefficients, a programmable rounding shift, a runtime border mode (zero or replicate) and frame-boundary shadowing of all host settings.
- Adds end-of-frame flush with an input-ready indication.
- Sits between a pixel source and a pixel sink in the DSP image path.

Parameters:
- IMG_W, 256, pixels per row (>=4)
- IMG_H, 256, rows per frame (>=3)
- DW, 8, pixel width, unsigned
- CW, 8, coefficient width, two's complement (>=5)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_strb  in  1  input pixel valid, one-cycle pulse per pixel; back-to-back allowed
- i_data  in  DW  input pixel
- i_ready  out  1  high when an input strobe will be accepted
- o_strb  out  1  output pixel valid, one-cycle pulse
- o_data  out  DW  filtered pixel, clamped
- h_write  in  1  host register write strobe
- h_idx  in  4  register index: 0-8 coefficients (row-major, 4 = centre), 9 shift (low 5 bits), 10 border mode (bit0: 0 zero, 1 replicate); 11-15 ignored
- h_data  in  CW  host write data
- o_err  out  1  sticky flag: strobe arrived while i_ready low

Behaviour:
- Reset values:
  - o_strb=0, o_data=0, i_ready=1, o_err=0.
  - Row/column counters 0.
  - Active and shadow coefficients set to identity (centre=1, others 0); shift=0; border=zero.
- Reset mid-frame discards partial frame and pipeline contents. The next strobe is pixel (0,0).
- Host writes always land in the shadow bank.
- Shadow-to-active commit happens on the cycle pixel (0,0) is accepted. A write in that same cycle applies to the next frame only.
- Pixel p = r*IMG_W+c is output when trigger index p+IMG_W+1 occurs:
  - For p+IMG_W+1 < IMG_W*IMG_H, the trigger is acceptance of that input pixel.
  - Otherwise the trigger is a flush tick.
- Flush:
  - The cycle after the last pixel of a frame is accepted, i_ready=0 for exactly IMG_W+1 cycles, one flush tick per cycle; then i_ready=1.
  - A strobe while i_ready=0 is dropped and sets o_err, which is cleared only by reset.
- Window: 3x3 around (r,c) from two line buffers plus a 3x3 register window.
  - Out-of-image neighbours are 0 (zero mode) or the nearest in-image pixel (replicate mode, edges and corners clamp independently in row and column).
- Arithmetic:
  - Each product is the unsigned pixel (zero-extended) times the signed coefficient.
  - Sum of 9 products in ACC = DW+CW+5 bits, signed.
  - If shift>0, add 2^(shift-1), then arithmetic right shift by shift.
  - Clamp to [0, 2^DW-1].
- Latency: o_strb asserts exactly 3 cycles after the trigger. Stage 1 registers window and products; stage 2 sums and rounds; stage 3 clamps and registers the output.
- Exactly IMG_W*IMG_H o_strb pulses per frame.
- A new frame may start on the cycle i_ready returns high; its pipeline overlaps the previous frame's tail without corruption.

Decomposition:
- Shared package filter2d_pkg holds:
  - host index constants (IDX_SHIFT=9, IDX_BORDER=10)
  - border-mode encodings
  - the ACC width function
  - the identity coefficient default
- One natural sub-module, filter2d_linebuf: two IMG_W-deep DW-bit row buffers with a shared write/read column address, advanced on accept or flush tick.

Test Plan:
- 4x4 params, reset defaults, pixels 0..15 back-to-back -> o_data 0..15 in order; first o_strb 3 cycles after pixel 5 accepted; i_ready low 5 cycles after pixel 15.
- All coefficients 1, shift 3, zero mode, constant 80 image -> interior 90, edges 60, corners 40; replicate mode -> all 90.
- Centre 4, shift 0, pixel 100 -> 255 (saturate). Centre -1 -> 0 (negative clamp). Shift 1 with centre 3, pixel 1 -> 2 (rounding).
- Mid-frame write of centre 2 -> current frame unchanged (identity); next frame outputs doubled values.
- Strobe while i_ready=0 -> pixel dropped, o_err=1 and stays 1; output count per frame still 16.
- 16 idle cycles between strobes, plus reset asserted mid-frame -> outputs 0 during reset; following full frame matches the identity expectation.
